serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Sequencer that time-shares one 1-bit full-adder cell (s = a^b^cin, c = majority) across the bits of two WIDTH-bit operands, LSB first, one bit per clock.
- Replaces a WIDTH-wide ripple adder where area matters more than latency.
- Supports add and subtract, a carry-in for chaining, and valid/ready handshakes on the input and output sides.

Parameters:
- WIDTH, 8, operand and sum width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, cin, sub are presented
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in, used when sub=0
- sub  input  1  1 = compute a - b (b inverted, initial carry forced to 1, cin ignored)
- out_valid  output  1  result fields are valid
- out_ready  input  1  consumer accepts result
- s  output  WIDTH  sum / difference
- c  output  1  carry-out (for sub: 1 = no borrow)
- ovf  output  1  signed two's-complement overflow
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, bit counter=0, carry FF=0, operand shift registers=0.
  - s=0, c=0, ovf=0, out_valid=0, busy=0, in_ready=1 (in_ready follows state, so high on reset release).
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1:
    - Load A shift reg <= a.
    - Load B shift reg <= (sub ? ~b : b).
    - Carry FF <= (sub ? 1 : cin).
    - Counter <= 0; clear s.
    - Go to RUN.
  - in_valid=0: stay in IDLE.
- RUN:
  - Each edge, the cell is fed A[0], B[0], carry FF.
  - Cell sum is shifted into the MSB of the s register (s shifts right).
  - Carry FF <= cell carry; A and B shift right by 1.
  - Counter increments.
  - On the edge where counter==WIDTH-1:
    - c <= cell carry.
    - ovf <= carry-into-MSB XOR carry-out-of-MSB.
    - Go to DONE.
  - RUN always lasts exactly WIDTH edges.
  - in_valid is ignored; in_ready=0.
- DONE:
  - out_valid=1; s, c, ovf held stable.
  - On an edge with out_ready=1: go to IDLE, out_valid drops the next cycle.
  - out_ready=0: hold indefinitely.
  - s, c, ovf keep their last values after DONE until the next load clears s.
- Latency:
  - Operands accepted at edge E0; out_valid high after edge E_WIDTH.
  - Earliest next acceptance is the edge after the out_ready handshake.
  - Minimum throughput: one operation per WIDTH+2 cycles.
- Width and arithmetic:
  - Result is (a + b + cin) mod 2^WIDTH, or (a - b) mod 2^WIDTH.
  - c is bit WIDTH of the full sum.
  - Counter is $clog2(WIDTH) bits and must not wrap within RUN.
- Boundaries:
  - in_valid held high through RUN/DONE starts no new operation; operands are re-sampled only in IDLE.
  - out_ready high before DONE has no effect.
  - rst_n asserted mid-RUN or in DONE aborts immediately to reset values; no partial result is presented.
  - cin is ignored when sub=1.
  - Back-to-back operations with out_ready and in_valid held high: DONE→IDLE→RUN with one IDLE cycle between them.

Test Plan:
- Reset → in_ready=1, out_valid=0, s=0.
- WIDTH=8; a=8'h5A, b=8'h3C, cin=0, sub=0 → out_valid exactly 8 edges after acceptance; s=8'h96, c=0, ovf=1.
- a=8'hFF, b=8'h01, cin=0 → s=8'h00, c=1, ovf=0.
- a=8'hFF, b=8'h00, cin=1 → s=8'h00, c=1.
- a=8'h10, b=8'h20, sub=1, cin=1 → s=8'hF0, c=0, ovf=0 (cin ignored).
- a=8'h80, b=8'h01, sub=1 → s=8'h7F, c=1, ovf=1.
- Hold out_ready=0 for 5 cycles in DONE → s, c, out_valid stable, in_ready=0.
- Toggle in_valid with new operands during RUN → result unaffected.
- Pulse rst_n low at RUN bit 3 → all outputs return to reset values at once.
- After release, a=8'h01, b=8'h01 → s=8'h02.

Source files
------------

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Bit-serial add/subtract sequencer that feeds one full-adder cell
//            LSB first, with valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             ovf,
  output logic             busy
);

  localparam int                 c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_s;
  logic               r_carry;
  logic               r_c;
  logic               r_ovf;
  logic [c_cnt_w-1:0] r_cnt;

  logic w_load;
  logic w_step;
  logic w_last;
  logic w_sum;
  logic w_cout;

  // The shared full-adder cell
  assign w_sum  = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_cout = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

  assign w_load = (r_state == ST_IDLE) && in_valid;
  assign w_step = (r_state == ST_RUN);
  assign w_last = w_step && (r_cnt == c_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_state_next = ST_RUN;
      ST_RUN:  if (w_last)    w_state_next = ST_DONE;
      ST_DONE: if (out_ready) w_state_next = ST_IDLE;
      default:                w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_c     <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      // Subtraction is a + ~b + 1, so the forced carry replaces cin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : cin;
      r_s     <= '0;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_s     <= {w_sum, r_s[WIDTH-1:1]};
      r_a     <= {1'b0, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_carry <= w_cout;
      r_cnt   <= r_cnt + c_one;
      if (w_last) begin
        // On the MSB step r_carry is the carry into the sign bit
        r_c   <= w_cout;
        r_ovf <= r_carry ^ w_cout;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign s         = r_s;
  assign c         = r_c;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_ctrl
// Purpose  : Self-checking bench for serial_add_ctrl against a cycle-level
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] s;
  logic         c;
  logic         ovf;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c         (c),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation is pending for W edges, then its result is shown
  int           m_left = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_s = '0;
  logic         m_c = 1'b0;
  logic         m_ovf = 1'b0;
  logic [W-1:0] p_s;
  logic         p_c;
  logic         p_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_s    = '0;
      m_c    = 1'b0;
      m_ovf  = 1'b0;
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_s    = p_s;
        m_c    = p_c;
        m_ovf  = p_ovf;
      end
    end else if (in_valid) begin
      logic [W-1:0] bv;
      logic [W:0]   full;
      bv    = sub ? ~b : b;
      full  = {1'b0, a} + {1'b0, bv} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
      p_s   = full[W-1:0];
      p_c   = full[W];
      p_ovf = (a[W-1] == bv[W-1]) && (p_s[W-1] != a[W-1]);
      m_left = W;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_idle;
      exp_idle = (m_left == 0) && !m_done;
      check("in_ready", 32'(in_ready), 32'(exp_idle));
      check("out_valid", 32'(out_valid), 32'(m_done));
      check("busy", 32'(busy), 32'(!exp_idle));
      if (exp_idle || m_done) begin
        check("s", 32'(s), 32'(m_s));
        check("c", 32'(c), 32'(m_c));
        check("ovf", 32'(ovf), 32'(m_ovf));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One directed operation with literal expectations and DONE-hold stability
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tcin, input logic tsub, input int hold,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    logic [W-1:0] s_hold;
    n = 0;
    while (!in_ready && n < 100) begin step(); n++; end
    check("idle_wait_timeout", 32'(in_ready), 32'd1);
    a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b0;
    step();
    n = 0;
    while (!out_valid && n < 50) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      a = W'($urandom); b = W'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      step();
      n++;
    end
    out_ready = 1'b0;
    check("latency", 32'(n), 32'(W));
    check("lit_model_s", 32'(m_s), 32'(es));
    check("lit_model_c", 32'(m_c), 32'(ec));
    check("lit_model_ovf", 32'(m_ovf), 32'(eo));
    check("lit_dut_s", 32'(s), 32'(es));
    check("lit_dut_c", 32'(c), 32'(ec));
    check("lit_dut_ovf", 32'(ovf), 32'(eo));
    s_hold = s;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      step();
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_s", 32'(s), 32'(s_hold));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    mon_en = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    step();

    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0, 8'h96, 1'b0, 1'b1);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0);
    do_op(8'hFF, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b1, 1'b0);
    do_op(8'h10, 8'h20, 1'b1, 1'b1, 0, 8'hF0, 1'b0, 1'b0);
    do_op(8'h80, 8'h01, 1'b0, 1'b1, 5, 8'h7F, 1'b1, 1'b1);

    // Abort mid-RUN after three bits have been processed
    a = 8'h33; b = 8'h44; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_s", 32'(s), 32'd0);
    check("abort_c", 32'(c), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_op(8'h01, 8'h01, 1'b0, 1'b0, 0, 8'h02, 1'b0, 1'b0);

    // Back-to-back with both handshakes held high
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom); b = W'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      step();
    end

    // Fully random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) == 0);
      out_ready = 1'($urandom_range(0, 1));
      a = W'($urandom); b = W'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      step();
    end

    in_valid = 1'b0; out_ready = 1'b1;
    repeat (W + 3) step();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
